des_key_schedule: RTL

- Sequential DES subkey generator. It sits directly upstream of the round F-function and drives its 48-bit Keyin port.
- Accepts a 64-bit key once, applies PC-1, then produces the 16 round subkeys one at a time through a valid/ready handshake.
- Rotates C/D left for encryption (K1..K16) or right for decryption (K16..K1).
- Bit numbering follows FIPS 46-3: bit 1 is the MSB of every vector.

---
 rtl/des_key_schedule.sv | 133 +++++++++++++
 1 files changed

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - sequential DES round subkey generator (PC-1, C/D rotation, PC-2)
module des_key_schedule #(
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:64] key_in,
  input  logic        key_load,
  input  logic        decrypt,
  input  logic        subkey_ready,
  output logic [1:48] subkey_out,
  output logic        subkey_valid,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam int PC1_TAB [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [1:48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] r;
    for (int i = 1; i <= 56; i++) r[i] = k[PC1_TAB[i]];
    return r;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    logic [1:48] r;
    for (int i = 1; i <= 48; i++) r[i] = cd[PC2_TAB[i]];
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; all others by two.
  function automatic logic single_shift(input logic [4:0] rnd);
    return (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
  endfunction

  function automatic logic [1:28] rot(input logic [1:28] x, input logic left, input logic one);
    logic [1:28] r;
    if (left) r = one ? {x[2:28], x[1]} : {x[3:28], x[1:2]};
    else      r = one ? {x[28], x[1:27]} : {x[27:28], x[1:26]};
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [1:28] c_q, c_d, d_q, d_d;
  logic        mode_q, mode_d;
  logic [4:0]  count_q, count_d;
  logic [1:56] pc_key;
  logic        one;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    mode_d  = mode_q;
    count_d = count_q;
    pc_key  = pc1(key_in);
    one     = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_load) begin
          // Total rotation is 28, so unrotated PC-1 is already K16 for decryption.
          c_d     = decrypt ? pc_key[1:28]  : rot(pc_key[1:28], 1'b1, 1'b1);
          d_d     = decrypt ? pc_key[29:56] : rot(pc_key[29:56], 1'b1, 1'b1);
          mode_d  = decrypt;
          count_d = 5'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (count_q == 5'd16) begin
            state_d = FIN;
          end else begin
            count_d = count_q + 5'd1;
            one     = mode_q ? single_shift(5'd17 - count_q) : single_shift(count_q + 5'd1);
            c_d     = rot(c_q, !mode_q, one);
            d_d     = rot(d_q, !mode_q, one);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      mode_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      mode_q  <= mode_d;
      count_q <= count_d;
    end
  end

  assign subkey_valid = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign done         = (state_q == FIN);
  // Round 16 wraps to 0 in the 4-bit field; qualify with subkey_valid.
  assign round_idx    = !subkey_valid ? 4'd0 :
                        mode_q ? 4'(5'd17 - count_q) : count_q[3:0];
  assign subkey_out   = (ZERO_IDLE && !subkey_valid) ? '0 : pc2({c_q, d_q});

endmodule
